// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its control block.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } aluOp_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcSrc_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcB_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic [31:0] signExt16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined operation codes produce zero.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  aluControl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (aluControl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register file
// and a single unified memory port, all steered by the external control word.
module mc_datapath
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcWriteCond,
    input  logic        pcWrite,
    input  logic        iOrD,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memToReg,
    input  logic        irWrite,
    input  logic [1:0]  pcSource,
    input  logic [1:0]  aluSrcB,
    input  logic        aluSrcA,
    input  logic        regWrite,
    input  logic        regDst,
    input  logic [2:0]  aluControl,
    input  logic [31:0] memRData,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic        memRe,
    output logic        memWe
);

    logic [31:0] pc, ir, mdr, regA, regB, aluOut;
    logic [31:0] regFile [32];

    logic [31:0] srcA, srcB, aluResult, nextPc, jumpTarget, imm;
    logic [31:0] rsVal, rtVal, writeData;
    logic [4:0]  rs, rt, rd, writeReg;
    logic        aluZero, pcEn;

    assign rs  = ir[25:21];
    assign rt  = ir[20:16];
    assign rd  = ir[15:11];
    assign imm = signExt16(ir[15:0]);

    // Register 0 is never written, but the read mux guarantees zero regardless.
    assign rsVal = (rs == 5'd0) ? '0 : regFile[rs];
    assign rtVal = (rt == 5'd0) ? '0 : regFile[rt];

    assign srcA = aluSrcA ? regA : pc;

    always_comb begin
        srcB = regB;
        case (aluSrcB)
            SRCB_REG:     srcB = regB;
            SRCB_FOUR:    srcB = 32'd4;
            SRCB_IMM:     srcB = imm;
            SRCB_IMM_SH2: srcB = {imm[29:0], 2'b00};
            default:      srcB = regB;
        endcase
    end

    alu uAlu (
        .a          (srcA),
        .b          (srcB),
        .aluControl (aluControl),
        .result     (aluResult),
        .zero       (aluZero)
    );

    assign jumpTarget = {pc[31:28], ir[25:0], 2'b00};

    always_comb begin
        nextPc = pc;
        case (pcSource)
            PCSRC_ALU:    nextPc = aluResult;
            PCSRC_ALUOUT: nextPc = aluOut;
            PCSRC_JUMP:   nextPc = jumpTarget;
            PCSRC_HOLD:   nextPc = pc;
            default:      nextPc = pc;
        endcase
    end

    assign pcEn      = pcWrite | (pcWriteCond & aluZero);
    assign writeReg  = regDst ? rd : rt;
    assign writeData = memToReg ? mdr : aluOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            regA   <= '0;
            regB   <= '0;
            aluOut <= '0;
        end else begin
            if (pcEn) pc <= nextPc;
            if (irWrite) ir <= memRData;
            mdr    <= memRData;
            regA   <= rsVal;
            regB   <= rtVal;
            aluOut <= aluResult;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (regWrite && (writeReg != 5'd0)) begin
            regFile[writeReg] <= writeData;
        end
    end

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign memAddr  = iOrD ? aluOut : pc;
    assign memWData = regB;
    assign memRe    = memRead;
    assign memWe    = memWrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: expected values queued with stimulus, popped at observation.
module tb_mc_datapath;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite;
    logic [1:0]  pcSource, aluSrcB;
    logic        aluSrcA, regWrite, regDst;
    logic [2:0]  aluControl;
    logic [31:0] memRData = '0;
    logic [5:0]  op, funct;
    logic [31:0] memAddr, memWData;
    logic        memRe, memWe;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    logic [31:0] expQ [$];
    logic [31:0] exp;
    logic [31:0] rdVal;

    mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pcWriteCond(pcWriteCond), .pcWrite(pcWrite),
        .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .irWrite(irWrite), .pcSource(pcSource), .aluSrcB(aluSrcB), .aluSrcA(aluSrcA),
        .regWrite(regWrite), .regDst(regDst), .aluControl(aluControl),
        .memRData(memRData), .op(op), .funct(funct), .memAddr(memAddr),
        .memWData(memWData), .memRe(memRe), .memWe(memWe)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pcWriteCond = 0; pcWrite = 0; iOrD = 0; memRead = 0; memWrite = 0;
        memToReg = 0; irWrite = 0; pcSource = 2'b11; aluSrcB = 2'b00;
        aluSrcA = 0; regWrite = 0; regDst = 0; aluControl = ALU_ADD;
    endtask

    task automatic setIr(input logic [31:0] instr);
        memRData = instr;
        irWrite = 1;
        tick();
        irWrite = 0;
    endtask

    // lw-style preload: IR names rt, MDR captures the value, then write back.
    task automatic writeReg(input logic [4:0] r, input logic [31:0] val);
        idle();
        setIr({OP_LW, 5'd0, r, 16'd0});
        memRData = val;
        tick();
        memToReg = 1; regDst = 0; regWrite = 1;
        tick();
        idle();
    endtask

    task automatic readReg(input logic [4:0] r, output logic [31:0] val);
        idle();
        setIr({OP_RTYPE, r, r, 5'd0, 5'd0, 6'h20});
        tick();
        val = memWData;
    endtask

    task automatic test_reset();
        idle();
        memRead = 1; memWrite = 1;
        #2 rst_n = 0;
        tick(); tick();
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL reset_memAddr: got %h expected %h", memAddr, exp); end
        exp = expQ.pop_front(); compared++;
        if ({26'b0, op} !== exp) begin mismatched++; $display("FAIL reset_op: got %h expected %h", op, exp); end
        exp = expQ.pop_front(); compared++;
        if ({26'b0, funct} !== exp) begin mismatched++; $display("FAIL reset_funct: got %h expected %h", funct, exp); end
        exp = expQ.pop_front(); compared++;
        if (memWData !== exp) begin mismatched++; $display("FAIL reset_memWData: got %h expected %h", memWData, exp); end
        compared++;
        if (memRe !== 1'b1 || memWe !== 1'b1) begin
            mismatched++; $display("FAIL passthru_hi: got re=%b we=%b expected 1 1", memRe, memWe);
        end
        memRead = 0; memWrite = 0; #1;
        compared++;
        if (memRe !== 1'b0 || memWe !== 1'b0) begin
            mismatched++; $display("FAIL passthru_lo: got re=%b we=%b expected 0 0", memRe, memWe);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_fetch();
        idle();
        memRData = 32'h012A4020;
        irWrite = 1; aluSrcA = 0; aluSrcB = 2'b01; aluControl = ALU_ADD;
        pcWrite = 1; pcSource = 2'b00;
        expQ.push_back(32'h0);
        #1;
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL fetch_addr_pre: got %h expected %h", memAddr, exp); end
        expQ.push_back(32'h0);
        expQ.push_back(32'h20);
        expQ.push_back(32'h4);
        expQ.push_back(32'h4);
        tick();
        idle();
        exp = expQ.pop_front(); compared++;
        if ({26'b0, op} !== exp) begin mismatched++; $display("FAIL fetch_op: got %h expected %h", op, exp); end
        exp = expQ.pop_front(); compared++;
        if ({26'b0, funct} !== exp) begin mismatched++; $display("FAIL fetch_funct: got %h expected %h", funct, exp); end
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL fetch_pc: got %h expected %h", memAddr, exp); end
        iOrD = 1; #1;
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL fetch_aluout: got %h expected %h", memAddr, exp); end
        idle();
    endtask

    task automatic test_rtype();
        logic [2:0]  ctl  [6] = '{ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, 3'b011, 3'b100};
        logic [31:0] want [6] = '{32'hFFFF_FFFE, 32'h1, 32'h5, 32'h7, 32'h0, 32'h0};
        writeReg(5'd9, 32'd5);
        writeReg(5'd10, 32'd7);
        setIr(32'h012A4020);
        tick();
        aluSrcA = 1; aluSrcB = 2'b00; aluControl = ALU_ADD; iOrD = 1;
        expQ.push_back(32'd12);
        expQ.push_back(32'd7);
        tick();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL rtype_add: got %h expected %h", memAddr, exp); end
        exp = expQ.pop_front(); compared++;
        if (memWData !== exp) begin mismatched++; $display("FAIL rtype_B: got %h expected %h", memWData, exp); end
        for (int i = 0; i < 6; i++) begin
            expQ.push_back(want[i]);
            aluControl = ctl[i];
            tick();
            exp = expQ.pop_front(); compared++;
            if (memAddr !== exp) begin
                mismatched++; $display("FAIL alu_op_%b: got %h expected %h", ctl[i], memAddr, exp);
            end
        end
        aluControl = ALU_ADD;
        tick();
        regWrite = 1; regDst = 1; memToReg = 0;
        tick();
        idle();
        expQ.push_back(32'd12);
        readReg(5'd8, rdVal);
        exp = expQ.pop_front(); compared++;
        if (rdVal !== exp) begin mismatched++; $display("FAIL rtype_wb_r8: got %h expected %h", rdVal, exp); end
    endtask

    task automatic test_lw();
        idle();
        setIr({OP_LW, 5'd0, 5'd11, 16'h0040});
        tick();
        aluSrcA = 1; aluSrcB = 2'b10; aluControl = ALU_ADD;
        tick();
        iOrD = 1; memRead = 1;
        expQ.push_back(32'h40);
        #1;
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp || memRe !== 1'b1) begin
            mismatched++; $display("FAIL lw_addr: got %h re=%b expected %h re=1", memAddr, memRe, exp);
        end
        memRData = 32'hDEAD_BEEF;
        tick();
        memToReg = 1; regDst = 0; regWrite = 1;
        expQ.push_back(32'h0);
        tick();
        exp = expQ.pop_front(); compared++;
        if (memWData !== exp) begin mismatched++; $display("FAIL lw_no_bypass: got %h expected %h", memWData, exp); end
        regWrite = 0;
        expQ.push_back(32'hDEAD_BEEF);
        tick();
        exp = expQ.pop_front(); compared++;
        if (memWData !== exp) begin mismatched++; $display("FAIL lw_wb_r11: got %h expected %h", memWData, exp); end
        aluSrcB = 2'b11;
        expQ.push_back(32'h100);
        tick();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL imm_shift2: got %h expected %h", memAddr, exp); end
        idle();
        setIr({OP_RTYPE, 5'd11, 5'd9, 16'h002A});
        tick();
        aluSrcA = 1; aluSrcB = 2'b00; aluControl = ALU_SLT; iOrD = 1;
        expQ.push_back(32'h1);
        tick();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL slt_signed: got %h expected %h", memAddr, exp); end
        idle();
    endtask

    task automatic test_beq();
        for (int c = 0; c < 2; c++) begin
            idle();
            setIr({OP_LW, 5'd0, 5'd0, 16'd8});
            tick();
            aluSrcA = 1; aluSrcB = 2'b10; pcWrite = 1; pcSource = 2'b00;
            tick();
            idle();
            setIr({OP_BEQ, 5'd9, (c == 0) ? 5'd9 : 5'd10, 16'd3});
            aluSrcA = 0; aluSrcB = 2'b11;
            tick();
            expQ.push_back((c == 0) ? 32'd20 : 32'd8);
            aluSrcA = 1; aluSrcB = 2'b00; aluControl = ALU_SUB;
            pcWriteCond = 1; pcSource = 2'b01;
            tick();
            idle();
            exp = expQ.pop_front(); compared++;
            if (memAddr !== exp) begin mismatched++; $display("FAIL beq_case%0d: got %h expected %h", c, memAddr, exp); end
        end
        pcWrite = 1; pcSource = 2'b11;
        expQ.push_back(32'd8);
        tick();
        idle();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL pc_hold: got %h expected %h", memAddr, exp); end
    endtask

    task automatic test_r0();
        writeReg(5'd0, 32'hFFFF_FFFF);
        expQ.push_back(32'h0);
        readReg(5'd0, rdVal);
        exp = expQ.pop_front(); compared++;
        if (rdVal !== exp) begin mismatched++; $display("FAIL r0_write: got %h expected %h", rdVal, exp); end
    endtask

    task automatic test_jump();
        writeReg(5'd12, 32'h1000_0004);
        setIr({OP_RTYPE, 5'd12, 5'd0, 16'h0000});
        tick();
        aluSrcA = 1; aluSrcB = 2'b10; aluControl = ALU_ADD; pcWrite = 1; pcSource = 2'b00;
        expQ.push_back(32'h1000_0004);
        tick();
        idle();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL jump_setup_pc: got %h expected %h", memAddr, exp); end
        setIr({OP_J, 26'h000_0100});
        pcWrite = 1; pcSource = 2'b10;
        expQ.push_back(32'h1000_0400);
        expQ.push_back({26'b0, OP_J});
        tick();
        idle();
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL jump_pc: got %h expected %h", memAddr, exp); end
        exp = expQ.pop_front(); compared++;
        if ({26'b0, op} !== exp) begin mismatched++; $display("FAIL jump_op: got %h expected %h", op, exp); end
    endtask

    task automatic test_async_reset();
        idle();
        @(posedge clk);
        #3;
        rst_n = 0;
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        #1;
        exp = expQ.pop_front(); compared++;
        if (memAddr !== exp) begin mismatched++; $display("FAIL async_rst_pc: got %h expected %h", memAddr, exp); end
        exp = expQ.pop_front(); compared++;
        if ({26'b0, op} !== exp) begin mismatched++; $display("FAIL async_rst_op: got %h expected %h", op, exp); end
        tick();
        rst_n = 1;
        expQ.push_back(32'h0);
        readReg(5'd8, rdVal);
        exp = expQ.pop_front(); compared++;
        if (rdVal !== exp) begin mismatched++; $display("FAIL async_rst_regfile: got %h expected %h", rdVal, exp); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_rtype();
        test_lw();
        test_beq();
        test_r0();
        test_jump();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
